decode_queue_stage: RTL

- Buffered decode stage between fetch and register-read.
- Accepts fetched instruction/PC pairs over a valid/ready handshake into a DEPTH-entry FIFO.
- Decodes the FIFO head into fields, sign-extended immediate and illegal flag; presents them from an output register with its own valid/ready handshake.
- Synchronous flush for branch redirect.

---
 rtl/dec_pkg.sv | 39 +++
 rtl/imm_gen.sv | 52 +++++
 rtl/decode_queue_stage.sv | 137 +++++++++++++
 3 files changed

// File: rtl/dec_pkg.sv
// Shared decode definitions: RV32I opcode constants, immediate selector and field split.
package dec_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_Z
    } imm_sel_e;

    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] func3;
        logic [1:0] func7;
        logic [4:0] rs1_index;
        logic [4:0] rs2_index;
        logic [4:0] rd_index;
    } fields_t;

    function automatic fields_t split_fields(input logic [31:0] inst);
        fields_t f;
        f.opcode    = inst[6:0];
        f.func3     = inst[14:12];
        f.func7     = {inst[30], inst[25]};
        f.rs1_index = inst[19:15];
        f.rs2_index = inst[24:20];
        f.rd_index  = inst[11:7];
        return f;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator and legality check for one instruction word.
// Optional macro CSR_DEC_EN makes SYSTEM legal with a zero-extended rs1-field immediate.
module imm_gen
    import dec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]            inst,
    output logic signed [XLEN-1:0] imm,
    output imm_sel_e               imm_sel,
    output logic                   illegal
);

    logic signed [31:0] imm32;

    always_comb begin
        imm_sel = IMM_NONE;
        illegal = 1'b0;
        case (inst[6:0])
            OP_LOAD, OP_IMM, OP_JALR: imm_sel = IMM_I;
            OP_STORE:                 imm_sel = IMM_S;
            OP_BRANCH:                imm_sel = IMM_B;
            OP_LUI, OP_AUIPC:         imm_sel = IMM_U;
            OP_JAL:                   imm_sel = IMM_J;
            OP_REG:                   imm_sel = IMM_NONE;
            OP_SYSTEM: begin
`ifdef CSR_DEC_EN
                imm_sel = IMM_Z;
`else
                illegal = 1'b1;
`endif
            end
            default:                  illegal = 1'b1;
        endcase
        if (inst[1:0] != 2'b11) illegal = 1'b1;
    end

    // Every format keeps inst[31] as its top bit, so a signed size cast does the extension.
    always_comb begin
        case (imm_sel)
            IMM_I:   imm32 = 32'($signed(inst[31:20]));
            IMM_S:   imm32 = 32'($signed({inst[31:25], inst[11:7]}));
            IMM_B:   imm32 = 32'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
            IMM_U:   imm32 = $signed({inst[31:12], 12'b0});
            IMM_J:   imm32 = 32'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
            IMM_Z:   imm32 = $signed({27'b0, inst[19:15]});
            default: imm32 = '0;
        endcase
        imm = XLEN'(imm32);
    end

endmodule

// File: rtl/decode_queue_stage.sv
// Buffered decode stage: DEPTH-entry fetch FIFO feeding a registered decode output with flush.
// Optional macro CSR_DEC_EN adds csr_addr/csr_r_pos outputs and accepts SYSTEM opcodes.
module decode_queue_stage
    import dec_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int PC_W  = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_inst,
    input  logic [PC_W-1:0]        in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PC_W-1:0]        out_pc,
    output logic [6:0]             opcode,
    output logic [2:0]             func3,
    output logic [1:0]             func7,
    output logic [4:0]             rs1_index,
    output logic [4:0]             rs2_index,
    output logic [4:0]             rd_index,
    output logic [XLEN-1:0]        imm,
    output logic                   illegal,
`ifdef CSR_DEC_EN
    output logic [11:0]            csr_addr,
    output logic                   csr_r_pos,
`endif
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      inst_mem [DEPTH];
    logic [PC_W-1:0]  pc_mem   [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             push, load;

    logic [31:0]            head_inst;
    logic signed [XLEN-1:0] head_imm;
    imm_sel_e               head_sel;
    logic                   head_ill;

    logic                   vld_p1;
    fields_t                fld_p1;
    logic [PC_W-1:0]        pc_p1;
    logic signed [XLEN-1:0] imm_p1;
    logic                   ill_p1;
`ifdef CSR_DEC_EN
    logic [11:0]            csr_addr_p1;
    logic                   csr_r_pos_p1;
`endif

    // in_ready looks only at occupancy, so a same-cycle pop frees a slot one cycle later.
    assign in_ready  = !rst && (cnt < CNT_W'(DEPTH));
    assign push      = in_valid && in_ready && !flush;
    assign load      = (!vld_p1 || out_ready) && (cnt != '0) && !flush;
    assign head_inst = inst_mem[rd_ptr];

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .inst    (head_inst),
        .imm     (head_imm),
        .imm_sel (head_sel),
        .illegal (head_ill)
    );

    // Stage 0: FIFO storage and pointers
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr] <= in_inst;
            pc_mem[wr_ptr]   <= in_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (load) rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CNT_W'(push) - CNT_W'(load);
        end
    end

    // Stage 1: decoded output register
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1       <= 1'b0;
            fld_p1       <= '0;
            pc_p1        <= '0;
            imm_p1       <= '0;
            ill_p1       <= 1'b0;
`ifdef CSR_DEC_EN
            csr_addr_p1  <= '0;
            csr_r_pos_p1 <= 1'b0;
`endif
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (load) begin
            vld_p1       <= 1'b1;
            fld_p1       <= split_fields(head_inst);
            pc_p1        <= pc_mem[rd_ptr];
            imm_p1       <= (head_sel == IMM_NONE) ? '0 : head_imm;
            ill_p1       <= head_ill;
`ifdef CSR_DEC_EN
            csr_addr_p1  <= head_inst[31:20];
            csr_r_pos_p1 <= head_inst[27];
`endif
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign out_pc    = pc_p1;
    assign opcode    = fld_p1.opcode;
    assign func3     = fld_p1.func3;
    assign func7     = fld_p1.func7;
    assign rs1_index = fld_p1.rs1_index;
    assign rs2_index = fld_p1.rs2_index;
    assign rd_index  = fld_p1.rd_index;
    assign imm       = imm_p1;
    assign illegal   = ill_p1;
    assign count     = cnt;
`ifdef CSR_DEC_EN
    assign csr_addr  = csr_addr_p1;
    assign csr_r_pos = csr_r_pos_p1;
`endif

endmodule
